// File: rtl/dmem_arbiter.sv
// Shares one fixed-latency data memory between the MEM-stage CPU port and a debug port.
// CPU has priority; debug is forced through after DBG_MAX_WAIT consecutive lost arbitrations.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int DBG_MAX_WAIT = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_ack,
  output logic              o_cpu_stall,
  input  logic              i_dbg_req,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  output logic [DATA_W-1:0] o_dbg_rdata,
  output logic              o_dbg_ack,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-3:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [1:0]        o_owner
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_CPU   = 2'd1;
  localparam logic [1:0] OWN_DBG   = 2'd2;
  localparam logic [3:0] WAIT_LOAD = 4'(MEM_LAT - 1);
  localparam logic [3:0] DBG_MAX   = 4'(DBG_MAX_WAIT);

  state_t              r_state;
  logic [1:0]          r_owner;
  logic                r_we;
  logic [ADDR_W-3:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [3:0]          r_wait;
  logic [3:0]          r_dbg_wait_cnt;
  logic                r_mem_en;
  logic                r_mem_we;
  logic                r_cpu_ack;
  logic                r_dbg_ack;

  logic w_dbg_wins;
  logic w_unused_addr_bits;

  assign w_dbg_wins = i_dbg_req & (~i_cpu_req | (r_dbg_wait_cnt == DBG_MAX));
  // Byte-offset bits are dropped on purpose; misalignment is silently ignored.
  assign w_unused_addr_bits = &{1'b0, i_cpu_addr[1:0], i_dbg_addr[1:0]};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_owner        <= OWN_NONE;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_wait         <= 4'd0;
      r_dbg_wait_cnt <= 4'd0;
      r_mem_en       <= 1'b0;
      r_mem_we       <= 1'b0;
      r_cpu_ack      <= 1'b0;
      r_dbg_ack      <= 1'b0;
    end else begin
      r_mem_en  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_dbg_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_dbg_wins) begin
            r_owner        <= OWN_DBG;
            r_we           <= i_dbg_we;
            r_addr         <= i_dbg_addr[ADDR_W-1:2];
            r_wdata        <= i_dbg_wdata;
            r_dbg_wait_cnt <= 4'd0;
            r_mem_en       <= 1'b1;
            r_mem_we       <= i_dbg_we;
            r_state        <= S_ISSUE;
          end else if (i_cpu_req) begin
            r_owner  <= OWN_CPU;
            r_we     <= i_cpu_we;
            r_addr   <= i_cpu_addr[ADDR_W-1:2];
            r_wdata  <= i_cpu_wdata;
            r_mem_en <= 1'b1;
            r_mem_we <= i_cpu_we;
            r_state  <= S_ISSUE;
            if (!i_dbg_req)
              r_dbg_wait_cnt <= 4'd0;
            else if (r_dbg_wait_cnt != DBG_MAX)
              r_dbg_wait_cnt <= r_dbg_wait_cnt + 4'd1;
          end else begin
            r_dbg_wait_cnt <= 4'd0;
          end
        end
        S_ISSUE: begin
          if (MEM_LAT > 1) begin
            r_wait  <= WAIT_LOAD;
            r_state <= S_WAIT;
          end else begin
            r_cpu_ack <= (r_owner == OWN_CPU);
            r_dbg_ack <= (r_owner == OWN_DBG);
            r_state   <= S_RESP;
          end
        end
        S_WAIT: begin
          if (r_wait == 4'd1) begin
            r_cpu_ack <= (r_owner == OWN_CPU);
            r_dbg_ack <= (r_owner == OWN_DBG);
            r_state   <= S_RESP;
          end else begin
            r_wait <= r_wait - 4'd1;
          end
        end
        S_RESP: begin
          r_owner <= OWN_NONE;
          r_state <= S_IDLE;
        end
        default: begin
          r_owner <= OWN_NONE;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Read data passes straight from memory during the ack cycle; writes return zero.
  assign o_cpu_rdata = (r_cpu_ack && !r_we) ? i_mem_rdata : '0;
  assign o_dbg_rdata = (r_dbg_ack && !r_we) ? i_mem_rdata : '0;
  assign o_cpu_ack   = r_cpu_ack;
  assign o_dbg_ack   = r_dbg_ack;
  assign o_cpu_stall = i_cpu_req & ~r_cpu_ack;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_owner     = r_owner;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: dutA runs MEM_LAT=2/DBG_MAX_WAIT=2, dutB runs MEM_LAT=1.
// Each DUT drives a small behavioural memory whose words reset to (index + 2).
module tb_dmem_arbiter;

  localparam logic [31:0] POISON = 32'hBAAD_F00D;

  logic        clock = 1'b0;
  logic        reset;

  logic        cpuReq, cpuWe, dbgReq, dbgWe;
  logic [31:0] cpuAddr, cpuWdata, dbgAddr, dbgWdata;
  logic [31:0] cpuRdata, dbgRdata, memWdata, memRdata;
  logic        cpuAck, cpuStall, dbgAck, memEn, memWe;
  logic [29:0] memAddr;
  logic [1:0]  owner;

  logic        bCpuReq, bCpuWe, bDbgReq, bDbgWe;
  logic [31:0] bCpuAddr, bCpuWdata, bDbgAddr, bDbgWdata;
  logic [31:0] bCpuRdata, bDbgRdata, bMemWdata, bMemRdata;
  logic        bCpuAck, bCpuStall, bDbgAck, bMemEn, bMemWe;
  logic [29:0] bMemAddr;
  logic [1:0]  bOwner;

  logic [31:0] memA [0:63];
  logic [31:0] memB [0:63];
  logic [31:0] rdA1, rdA2, rdB1;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clock = ~clock;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .DBG_MAX_WAIT(2)) u_dutA (
    .i_clk(clock), .i_reset(reset),
    .i_cpu_req(cpuReq), .i_cpu_we(cpuWe), .i_cpu_addr(cpuAddr), .i_cpu_wdata(cpuWdata),
    .o_cpu_rdata(cpuRdata), .o_cpu_ack(cpuAck), .o_cpu_stall(cpuStall),
    .i_dbg_req(dbgReq), .i_dbg_we(dbgWe), .i_dbg_addr(dbgAddr), .i_dbg_wdata(dbgWdata),
    .o_dbg_rdata(dbgRdata), .o_dbg_ack(dbgAck),
    .o_mem_en(memEn), .o_mem_we(memWe), .o_mem_addr(memAddr), .o_mem_wdata(memWdata),
    .i_mem_rdata(memRdata), .o_owner(owner)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .DBG_MAX_WAIT(3)) u_dutB (
    .i_clk(clock), .i_reset(reset),
    .i_cpu_req(bCpuReq), .i_cpu_we(bCpuWe), .i_cpu_addr(bCpuAddr), .i_cpu_wdata(bCpuWdata),
    .o_cpu_rdata(bCpuRdata), .o_cpu_ack(bCpuAck), .o_cpu_stall(bCpuStall),
    .i_dbg_req(bDbgReq), .i_dbg_we(bDbgWe), .i_dbg_addr(bDbgAddr), .i_dbg_wdata(bDbgWdata),
    .o_dbg_rdata(bDbgRdata), .o_dbg_ack(bDbgAck),
    .o_mem_en(bMemEn), .o_mem_we(bMemWe), .o_mem_addr(bMemAddr), .o_mem_wdata(bMemWdata),
    .i_mem_rdata(bMemRdata), .o_owner(bOwner)
  );

  // Memory models: read data appears exactly MEM_LAT cycles after the strobe, poison otherwise.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) begin
        memA[i] <= 32'(i + 2);
        memB[i] <= 32'(i + 2);
      end
      rdA1 <= POISON;
      rdA2 <= POISON;
      rdB1 <= POISON;
    end else begin
      if (memEn && memWe) memA[memAddr[5:0]] <= memWdata;
      rdA1 <= (memEn && !memWe) ? memA[memAddr[5:0]] : POISON;
      rdA2 <= rdA1;
      if (bMemEn && bMemWe) memB[bMemAddr[5:0]] <= bMemWdata;
      rdB1 <= (bMemEn && !bMemWe) ? memB[bMemAddr[5:0]] : POISON;
    end
  end

  assign memRdata  = rdA2;
  assign bMemRdata = rdB1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    else
      passCount++;
  endtask

  task automatic applyStimulus(input logic cReq, input logic cWe, input logic [31:0] cAddr,
                               input logic [31:0] cData, input logic dReq, input logic dWe,
                               input logic [31:0] dAddr, input logic [31:0] dData);
    cpuReq = cReq; cpuWe = cWe; cpuAddr = cAddr; cpuWdata = cData;
    dbgReq = dReq; dbgWe = dWe; dbgAddr = dAddr; dbgWdata = dData;
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int expCnt [3];
    logic [1:0] expOwner [3];
    expCnt   = '{0, 1, 2};
    expOwner = '{2'd1, 2'd1, 2'd2};

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    bCpuReq = 1'b0; bCpuWe = 1'b0; bCpuAddr = 32'h0; bCpuWdata = 32'h0;
    bDbgReq = 1'b0; bDbgWe = 1'b0; bDbgAddr = 32'h0; bDbgWdata = 32'h0;

    // Reset values, and stall following cpu_req while reset is held
    tick();
    checkOutput("rst_mem_en", 32'(memEn), 32'd0);
    checkOutput("rst_owner", 32'(owner), 32'd0);
    checkOutput("rst_mem_addr", 32'(memAddr), 32'd0);
    checkOutput("rst_cpu_ack", 32'(cpuAck), 32'd0);
    checkOutput("rst_dbg_ack", 32'(dbgAck), 32'd0);
    checkOutput("rst_wait_cnt", 32'(u_dutA.r_dbg_wait_cnt), 32'd0);
    cpuReq = 1'b1;
    #1;
    checkOutput("rst_stall_follows_req", 32'(cpuStall), 32'd1);
    cpuReq = 1'b0;
    #1;
    reset = 1'b0;
    tick();

    // CPU read of word 3 (value 5), MEM_LAT=2
    applyStimulus(1'b1, 1'b0, 32'h0C, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("t1_stall_c0", 32'(cpuStall), 32'd1);
    tick();
    checkOutput("t1_mem_en_c1", 32'(memEn), 32'd1);
    checkOutput("t1_mem_we_c1", 32'(memWe), 32'd0);
    checkOutput("t1_mem_addr_c1", 32'(memAddr), 32'd3);
    checkOutput("t1_owner_c1", 32'(owner), 32'd1);
    cpuAddr = 32'h20;
    tick();
    checkOutput("t1_mem_en_c2", 32'(memEn), 32'd0);
    checkOutput("t1_addr_latched_c2", 32'(memAddr), 32'd3);
    checkOutput("t1_ack_c2", 32'(cpuAck), 32'd0);
    checkOutput("t1_stall_c2", 32'(cpuStall), 32'd1);
    tick();
    checkOutput("t1_ack_c3", 32'(cpuAck), 32'd1);
    checkOutput("t1_rdata_c3", cpuRdata, 32'd5);
    checkOutput("t1_stall_c3", 32'(cpuStall), 32'd0);
    checkOutput("t1_dbg_rdata_c3", dbgRdata, 32'd0);
    cpuReq = 1'b0;
    tick();
    checkOutput("t1_owner_idle", 32'(owner), 32'd0);
    checkOutput("t1_ack_gone", 32'(cpuAck), 32'd0);

    // Debug write then held-request readback on dutB, MEM_LAT=1
    bDbgReq = 1'b1; bDbgWe = 1'b1; bDbgAddr = 32'h10; bDbgWdata = 32'hDEAD;
    tick();
    checkOutput("t2_mem_en", 32'(bMemEn), 32'd1);
    checkOutput("t2_mem_we", 32'(bMemWe), 32'd1);
    checkOutput("t2_mem_addr", 32'(bMemAddr), 32'd4);
    checkOutput("t2_mem_wdata", bMemWdata, 32'hDEAD);
    tick();
    checkOutput("t2_dbg_ack", 32'(bDbgAck), 32'd1);
    checkOutput("t2_cpu_ack", 32'(bCpuAck), 32'd0);
    checkOutput("t2_wr_rdata_zero", bDbgRdata, 32'd0);
    bDbgWe = 1'b0;
    tick();
    checkOutput("t2_idle_gap", 32'(bMemEn), 32'd0);
    tick();
    checkOutput("t2_rd_issue", 32'(bMemEn), 32'd1);
    tick();
    checkOutput("t2_rd_ack", 32'(bDbgAck), 32'd1);
    checkOutput("t2_readback", bDbgRdata, 32'hDEAD);
    bDbgReq = 1'b0;
    tick();

    // Simultaneous requests: CPU write first, then debug reads the same word
    applyStimulus(1'b1, 1'b1, 32'h14, 32'h77, 1'b1, 1'b0, 32'h14, 32'h0);
    tick();
    checkOutput("t3_owner_cpu", 32'(owner), 32'd1);
    checkOutput("t3_mem_we", 32'(memWe), 32'd1);
    checkOutput("t3_cnt_1", 32'(u_dutA.r_dbg_wait_cnt), 32'd1);
    tick();
    tick();
    checkOutput("t3_cpu_ack", 32'(cpuAck), 32'd1);
    checkOutput("t3_dbg_not_ack", 32'(dbgAck), 32'd0);
    cpuReq = 1'b0; cpuWe = 1'b0;
    tick();
    checkOutput("t3_idle_owner", 32'(owner), 32'd0);
    checkOutput("t3_idle_mem_en", 32'(memEn), 32'd0);
    tick();
    checkOutput("t3_owner_dbg", 32'(owner), 32'd2);
    checkOutput("t3_dbg_mem_en", 32'(memEn), 32'd1);
    checkOutput("t3_cnt_cleared", 32'(u_dutA.r_dbg_wait_cnt), 32'd0);
    tick();
    tick();
    checkOutput("t3_dbg_ack", 32'(dbgAck), 32'd1);
    checkOutput("t3_dbg_rdata", dbgRdata, 32'h77);
    checkOutput("t3_cpu_rdata_zero", cpuRdata, 32'd0);
    dbgReq = 1'b0;
    tick();

    // Starvation bound: both held, debug forced through on the third decision
    applyStimulus(1'b1, 1'b0, 32'h0C, 32'h0, 1'b1, 1'b0, 32'h18, 32'h0);
    for (int d = 0; d < 3; d++) begin
      #1;
      checkOutput($sformatf("t4_cnt_before_%0d", d), 32'(u_dutA.r_dbg_wait_cnt), 32'(expCnt[d]));
      tick();
      checkOutput($sformatf("t4_owner_%0d", d), 32'(owner), 32'(expOwner[d]));
      if (d == 2)
        checkOutput("t4_cnt_after_grant", 32'(u_dutA.r_dbg_wait_cnt), 32'd0);
      tick();
      tick();
      if (d < 2) begin
        checkOutput($sformatf("t4_cpu_rdata_%0d", d), cpuRdata, 32'd5);
      end else begin
        checkOutput("t4_dbg_rdata", dbgRdata, 32'd8);
        cpuReq = 1'b0;
        dbgReq = 1'b0;
      end
      tick();
    end

    // Reset in WAIT aborts the access, then a fresh read completes normally
    applyStimulus(1'b1, 1'b0, 32'h0C, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    #1;
    reset = 1'b1;
    #1;
    checkOutput("t5_async_owner", 32'(owner), 32'd0);
    checkOutput("t5_async_addr", 32'(memAddr), 32'd0);
    checkOutput("t5_stall_held", 32'(cpuStall), 32'd1);
    tick();
    checkOutput("t5_no_ack", 32'(cpuAck), 32'd0);
    #1;
    reset = 1'b0;
    tick();
    checkOutput("t5_reissue", 32'(memAddr), 32'd3);
    tick();
    checkOutput("t5_wait_no_ack", 32'(cpuAck), 32'd0);
    tick();
    checkOutput("t5_ack", 32'(cpuAck), 32'd1);
    checkOutput("t5_rdata", cpuRdata, 32'd5);
    cpuReq = 1'b0;
    tick();

    // Sweep: CPU writes 1..10 to words 3..12 (misaligned low bits), debug reads them back
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 32'((3 + i) * 4 + (i % 4)), 32'(i + 1), 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      checkOutput($sformatf("t6_wr_addr_%0d", i), 32'(memAddr), 32'(3 + i));
      checkOutput($sformatf("t6_wr_data_%0d", i), memWdata, 32'(i + 1));
      tick();
      tick();
      checkOutput($sformatf("t6_wr_ack_%0d", i), 32'(cpuAck), 32'd1);
      cpuReq = 1'b0;
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'((3 + i) * 4), 32'h0);
      tick();
      tick();
      tick();
      checkOutput($sformatf("t6_rd_ack_%0d", i), 32'(dbgAck), 32'd1);
      checkOutput($sformatf("t6_rd_data_%0d", i), dbgRdata, 32'(i + 1));
      dbgReq = 1'b0;
      tick();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
